// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: FSM states and PC stepping constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_t;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_STEP = 4;

    // Clears the two byte-offset bits; sliced down to the PC width at use sites.
    localparam logic [63:0] PC_ALIGN_MASK = ~64'(3);

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Ready/valid enqueue channel between the PC generator and the fetch queue.
interface fetch_pc_gen_if #(
    parameter int unsigned PC_WIDTH = 32
) ();

    logic                enq_valid;
    logic [PC_WIDTH-1:0] enq_data;
    logic                enq_ready;

    modport master (
        output enq_valid,
        output enq_data,
        input  enq_ready
    );

    modport slave (
        input  enq_valid,
        input  enq_data,
        output enq_ready
    );

endinterface

// File: rtl/up_counter.sv
// Wrapping up-counter with synchronous clear (priority) and count enable.
module up_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // Next count: clear wins over enable; natural wrap at 2^WIDTH.
    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en) begin
            w_count_next = r_count + WIDTH'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_pc_gen.sv
// Sequential word-aligned PC generator feeding the fetch queue over ready/valid,
// with redirect, halt and synchronous init support.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_aH,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    fetch_pc_gen_if.master         enq,
    output logic [COUNT_WIDTH-1:0] issued_count,
    output logic [1:0]             state,
    input  logic                   init,
    input  logic [PC_WIDTH-1:0]    init_pc_state
);

    localparam logic [PC_WIDTH-1:0] AlignMask = PC_ALIGN_MASK[PC_WIDTH-1:0];

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_valid;
    logic                w_hs;

    // Offer depends only on state and redirect; enq_ready never reaches an output.
    assign w_valid       = (r_state == StRun) && !redirect_valid;
    assign w_hs          = w_valid && enq.enq_ready;
    assign enq.enq_valid = w_valid;
    assign enq.enq_data  = r_pc;
    assign state         = r_state;

    // Next PC and state: init, then redirect, then normal handshake/FSM flow.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (init) begin
            w_pc_next    = init_pc_state & AlignMask;
            w_state_next = StRun;
        end else if (redirect_valid) begin
            // Redirect keeps the state; the offer is suppressed this cycle.
            w_pc_next = redirect_pc & AlignMask;
        end else begin
            if (w_hs) begin
                w_pc_next = r_pc + PC_WIDTH'(PC_STEP);
            end
            unique case (r_state)
                StIdle: if (start) w_state_next = StRun;
                // Halt only takes effect once the pending offer has been accepted.
                StRun:  if (halt && w_hs) w_state_next = StHalt;
                StHalt: if (!halt) w_state_next = StRun;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    up_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_issued_cnt (
        .clk     (clk),
        .rst     (rst_aH),
        .i_clr   (init),
        .i_en    (w_hs),
        .o_count (issued_count)
    );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed, table-driven bench for fetch_pc_gen.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst_aH;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] issued_count;
    logic [1:0]  state;
    logic        init;
    logic [31:0] init_pc_state;

    int checks;
    int failures;

    fetch_pc_gen_if #(.PC_WIDTH(32)) u_if ();

    fetch_pc_gen #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'h0000_0100),
        .COUNT_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst_aH         (rst_aH),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .enq            (u_if),
        .issued_count   (issued_count),
        .state          (state),
        .init           (init),
        .init_pc_state  (init_pc_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        halt;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        init;
        logic [31:0] ipc;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [15:0] exp_count;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic hl, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ini, input logic [31:0] ipc,
                       input logic ev, input logic [31:0] ed, input logic [15:0] ec,
                       input logic [1:0] es);
        vec_t v;
        v.start = st; v.halt = hl; v.rv = rv; v.rpc = rpc; v.ready = rdy;
        v.init = ini; v.ipc = ipc;
        v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_state = es;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hl, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic ini, input logic [31:0] ipc);
        start = st; halt = hl; redirect_valid = rv; redirect_pc = rpc;
        u_if.enq_ready = rdy; init = ini; init_pc_state = ipc;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ed,
                              input logic [15:0] ec, input logic [1:0] es);
        check({tag, ".valid"}, 64'(u_if.enq_valid), 64'(ev));
        check({tag, ".data"},  64'(u_if.enq_data),  64'(ed));
        check({tag, ".count"}, 64'(issued_count),   64'(ec));
        check({tag, ".state"}, 64'(state),          64'(es));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_aH = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);

        // Each row is one cycle: inputs applied, outputs expected before the next edge.
        //   st hl rv rpc          rdy in ipc           ev data          cnt st
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0000_0100, 0, 0); // reset state
        add(1, 0, 0, 32'h0,       1, 0, 32'h0,       0, 32'h0000_0100, 0, 0); // start
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_0100, 0, 1);
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_0104, 1, 1);
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_0108, 2, 1);
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_010C, 3, 1);
        add(0, 0, 1, 32'h200,     1, 0, 32'h0,       0, 32'h0000_010C, 3, 1); // redirect
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0200, 3, 1); // backpressure x4
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0200, 3, 1);
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0200, 3, 1);
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0200, 3, 1);
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_0200, 3, 1); // accept
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0204, 4, 1);
        add(0, 0, 1, 32'h120,     0, 0, 32'h0,       0, 32'h0000_0204, 4, 1);
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0120, 4, 1); // pending 0x120
        add(0, 0, 1, 32'h8003,    1, 0, 32'h0,       0, 32'h0000_0120, 4, 1); // redirect wins
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_8000, 4, 1);
        add(0, 1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_8000, 4, 1); // halt, no ready
        add(0, 1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_8000, 4, 1);
        add(0, 1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_8000, 4, 1); // accept -> HALT
        add(0, 1, 0, 32'h0,       1, 0, 32'h0,       0, 32'h0000_8004, 5, 2);
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0000_8004, 5, 2); // release halt
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_8004, 5, 1);
        add(1, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_8008, 6, 1); // start ignored
        add(0, 0, 0, 32'h0,       1, 1, 32'hFFFF_FFFF, 1, 32'h0000_8008, 6, 1); // init
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'hFFFF_FFFC, 0, 1);
        add(0, 0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0000_0000, 1, 1); // wrap
        add(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0000_0004, 2, 1);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_aH = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].halt, tbl[i].rv, tbl[i].rpc, tbl[i].ready,
                  tbl[i].init, tbl[i].ipc);
            #1;
            check_outs($sformatf("v%0d", i), tbl[i].exp_valid, tbl[i].exp_data,
                       tbl[i].exp_count, tbl[i].exp_state);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stream: offer of 0x4 pending, count=2.
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        #2;
        rst_aH = 1'b1;
        #1;
        check_outs("async_rst", 0, 32'h0000_0100, 0, 0);
        @(posedge clk);
        #1;
        rst_aH = 1'b0;

        // Redirect in IDLE loads the PC but stays in IDLE; start then offers the target.
        drive(0, 0, 1, 32'h0000_0302, 1, 0, 32'h0);
        #1;
        check_outs("idle_redir", 0, 32'h0000_0100, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        check_outs("idle_hold", 0, 32'h0000_0300, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        check_outs("idle_start", 1, 32'h0000_0300, 0, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        check_outs("idle_next", 1, 32'h0000_0304, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
